// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the decode stage: widths, instruction field
// positions and opcode encodings.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 16;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RD_MSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef logic [5:0]            opcode_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [IMM_W-1:0]      imm16_t;

    localparam opcode_t OP_RTYPE = 6'b100000;
    localparam opcode_t OP_ADDI  = 6'b110000;
    localparam opcode_t OP_LI    = 6'b111000;
    localparam opcode_t OP_LUI   = 6'b111001;
    localparam opcode_t OP_ANDI  = 6'b110010;
    localparam opcode_t OP_ORI   = 6'b110011;
    localparam opcode_t OP_B     = 6'b111111;
    localparam opcode_t OP_BEQ   = 6'b000000;
    localparam opcode_t OP_BNE   = 6'b000001;
    localparam opcode_t OP_LB    = 6'b000011;
    localparam opcode_t OP_LW    = 6'b001111;
    localparam opcode_t OP_SB    = 6'b000111;
    localparam opcode_t OP_SW    = 6'b011111;

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bus: instruction and write-back inputs, immediate and
// register read outputs.
interface instruction_decode_if;

    cpu_pkg::word_t Instr;
    logic           RF_WrEn;
    cpu_pkg::word_t ALU_out;
    cpu_pkg::word_t MEM_out;
    logic           RF_WrData_sel;
    logic           RF_Bsel;
    cpu_pkg::word_t Immed;
    cpu_pkg::word_t RF_A;
    cpu_pkg::word_t RF_B;

    modport master (
        output Instr, RF_WrEn, ALU_out, MEM_out, RF_WrData_sel, RF_Bsel,
        input  Immed, RF_A, RF_B
    );

    modport slave (
        input  Instr, RF_WrEn, ALU_out, MEM_out, RF_WrData_sel, RF_Bsel,
        output Immed, RF_A, RF_B
    );

endinterface

// File: rtl/register_file.sv
// 32x32 general-purpose register file: synchronous clear and write,
// two combinational read ports, R0 hard-wired to zero.
module register_file
    import cpu_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  reg_addr_t Ard1,
    input  reg_addr_t Ard2,
    input  reg_addr_t Awr,
    input  word_t     Din,
    input  logic      WrEn,
    output word_t     Dout1,
    output word_t     Dout2
);

    word_t regs_r [NREGS];

    // Register array update: clear has priority over a write, R0 is never stored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (WrEn && (Awr != {REG_ADDR_W{1'b0}})) begin
            regs_r[Awr] <= Din;
        end
    end

    // Read ports: no bypass, so a same-cycle write shows up only after the edge.
    always_comb begin
        Dout1 = {DATA_W{1'b0}};
        Dout2 = {DATA_W{1'b0}};
        if (Ard1 != {REG_ADDR_W{1'b0}}) begin
            Dout1 = regs_r[Ard1];
        end else begin
            Dout1 = {DATA_W{1'b0}};
        end
        if (Ard2 != {REG_ADDR_W{1'b0}}) begin
            Dout2 = regs_r[Ard2];
        end else begin
            Dout2 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: register file plus write-back mux, second read-address
// select and opcode-driven immediate extender.
module instruction_decode
    import cpu_pkg::*;
(
    input logic                 Clk,
    input logic                 Reset,
    instruction_decode_if.slave dec
);

    opcode_t   opcode_s;
    reg_addr_t rs_s;
    reg_addr_t rd_s;
    reg_addr_t rt_s;
    reg_addr_t rd_b_addr_s;
    imm16_t    imm16_s;
    word_t     wr_data_s;
    word_t     immed_s;

    assign opcode_s = dec.Instr[OPC_MSB:OPC_LSB];
    assign rs_s     = dec.Instr[RS_MSB:RS_LSB];
    assign rd_s     = dec.Instr[RD_MSB:RD_LSB];
    assign rt_s     = dec.Instr[RT_MSB:RT_LSB];
    assign imm16_s  = dec.Instr[IMM_MSB:IMM_LSB];

    // Write-back source and second read address selection.
    always_comb begin
        wr_data_s   = dec.ALU_out;
        rd_b_addr_s = rt_s;
        if (dec.RF_WrData_sel) begin
            wr_data_s = dec.MEM_out;
        end else begin
            wr_data_s = dec.ALU_out;
        end
        if (dec.RF_Bsel) begin
            rd_b_addr_s = rd_s;
        end else begin
            rd_b_addr_s = rt_s;
        end
    end

    // Immediate extender: branch offsets are word offsets, hence the shift by 2.
    always_comb begin
        immed_s = {{16{imm16_s[15]}}, imm16_s};
        case (opcode_s)
            OP_LUI:               immed_s = {imm16_s, 16'h0000};
            OP_ANDI, OP_ORI:      immed_s = {16'h0000, imm16_s};
            OP_B, OP_BEQ, OP_BNE: immed_s = {{14{imm16_s[15]}}, imm16_s, 2'b00};
            OP_ADDI, OP_LI, OP_LB, OP_LW, OP_SB, OP_SW, OP_RTYPE:
                                  immed_s = {{16{imm16_s[15]}}, imm16_s};
            default:              immed_s = {{16{imm16_s[15]}}, imm16_s};
        endcase
    end

    assign dec.Immed = immed_s;

    register_file u_register_file (
        .Clk   (Clk),
        .Reset (Reset),
        .Ard1  (rs_s),
        .Ard2  (rd_b_addr_s),
        .Awr   (rd_s),
        .Din   (wr_data_s),
        .WrEn  (dec.RF_WrEn),
        .Dout1 (dec.RF_A),
        .Dout2 (dec.RF_B)
    );

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed and random stimulus
// checked against a behavioural register-file / immediate model.
module tb_instruction_decode;

    logic Clk;
    logic Reset;

    instruction_decode_if dif ();

    instruction_decode dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dec   (dif)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        bit          chk_rf;
        string       tag;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_rf [32];
    int          n_cmp = 0;
    int          n_err = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_imm(input logic [31:0] instr);
        logic [5:0]  op;
        logic [15:0] imm;
        int          sx;
        op  = instr[31:26];
        imm = instr[15:0];
        sx  = $signed(imm);
        if (op == 6'b111001)
            return 32'(imm) << 16;
        else if (op == 6'b110010 || op == 6'b110011)
            return 32'(imm);
        else if (op == 6'b111111 || op == 6'b000000 || op == 6'b000001)
            return 32'(sx * 4);
        else
            return 32'(sx);
    endfunction

    function automatic logic [31:0] rf_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model_rf[idx];
    endfunction

    task automatic check(input string tag, input string port,
                         input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s %s: got %h want %h", tag, port, got, want);
        end
    endtask

    // Drive one cycle, queue the expected reads, then apply the edge to the model.
    task automatic apply(input logic [31:0] instr, input logic wren,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic wsel, input logic bsel, input logic rst,
                         input bit chk_rf, input string tag);
        exp_t       e;
        logic [4:0] rs, rd, rt;
        @(negedge Clk);
        Reset             = rst;
        dif.Instr         = instr;
        dif.RF_WrEn       = wren;
        dif.ALU_out       = alu;
        dif.MEM_out       = mem;
        dif.RF_WrData_sel = wsel;
        dif.RF_Bsel       = bsel;
        rs = instr[25:21];
        rd = instr[20:16];
        rt = instr[15:11];
        e.a      = rf_rd(rs);
        e.b      = rf_rd(bsel ? rd : rt);
        e.imm    = ref_imm(instr);
        e.chk_rf = chk_rf;
        e.tag    = tag;
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        end else if (wren && rd != 5'd0) begin
            model_rf[rd] = wsel ? mem : alu;
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle after the inputs settle.
    always begin
        @(negedge Clk);
        #2;
        while (sb_q.size() > 0) begin : pop_blk
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk_rf) begin
                check(e.tag, "RF_A", dif.RF_A, e.a);
                check(e.tag, "RF_B", dif.RF_B, e.b);
            end
            check(e.tag, "Immed", dif.Immed, e.imm);
        end
    end

    initial begin
        logic [5:0] ops [8];
        ops[0] = 6'b111001; ops[1] = 6'b110011; ops[2] = 6'b000000; ops[3] = 6'b111000;
        ops[4] = 6'b110010; ops[5] = 6'b111111; ops[6] = 6'b000001; ops[7] = 6'b001111;
        Reset             = 1'b0;
        dif.Instr         = 32'd0;
        dif.RF_WrEn       = 1'b0;
        dif.ALU_out       = 32'd0;
        dif.MEM_out       = 32'd0;
        dif.RF_WrData_sel = 1'b0;
        dif.RF_Bsel       = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

        // Register contents are unknown before the first reset edge.
        apply(32'h0000_8004, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");

        for (int r = 0; r < 32; r++) begin
            apply({6'b110000, 5'd4, 5'(r), 16'h8004}, 1'b1,
                  (r == 0) ? 32'd1 : 32'(r), 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "fill");
        end
        apply({6'b110000, 5'd4, 5'd9, 16'h8004}, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "fill_read");

        apply({6'b110000, 5'd0, 5'd0, 16'h0000}, 1'b1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "r0_write");
        apply({6'b110000, 5'd0, 5'd0, 16'h0000}, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "r0_read");

        apply({6'b110000, 5'd0, 5'd0, 5'b00111, 11'd0}, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "bsel_rt");

        apply({6'b110000, 5'd0, 5'd5, 16'h0000}, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, "wr_mem");
        apply({6'b110000, 5'd5, 5'd5, 16'h0000}, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "rd_mem");

        for (int k = 0; k < 8; k++) begin
            apply({ops[k], 5'd1, 5'd2, 16'h8004}, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "immed");
        end

        for (int n = 0; n < 300; n++) begin
            apply($urandom(), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), 1'b1, "random");
        end

        for (int r = 1; r < 32; r++) begin
            apply({6'b110000, 5'd0, 5'(r), 16'h0000}, 1'b1, 32'(r) * 32'h0101_0101,
                  32'd0, 1'b0, 1'b1, 1'b0, 1'b1, "reload");
        end
        apply({6'b110000, 5'd3, 5'd7, 16'h0000}, 1'b1, 32'hAAAA_5555, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, "reset_wr");
        for (int k = 0; k < 16; k++) begin
            apply({6'b110000, 5'(2 * k), 5'(2 * k + 1), 5'(2 * k + 1), 11'd0}, 1'b0,
                  32'd0, 32'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, "post_reset");
        end

        repeat (2) @(negedge Clk);
        #3;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the 32-bit multicycle/single-cycle CPU datapath.
- Holds the 32x32 general-purpose register file and provides two combinational read ports (RF_A, RF_B).
- Provides a write-back port selecting between ALU and memory results, and an opcode-driven immediate extender (Immed).
- Sits between instruction fetch (Instr) and the execute/memory stages (ALU_out, MEM_out fed back).

Parameters:
- DATA_W, 32, register/data width
- NREGS, 32, number of registers (5-bit addresses)

Ports:
- Clk  in  1  system clock, rising-edge active
- Reset  in  1  synchronous, active-high reset
- Instr  in  32  current instruction: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], imm16[15:0]
- RF_WrEn  in  1  register-file write enable
- ALU_out  in  32  write-back candidate from ALU
- MEM_out  in  32  write-back candidate from data memory
- RF_WrData_sel  in  1  0 = write ALU_out, 1 = write MEM_out
- RF_Bsel  in  1  second read address select: 0 = rt (Instr[15:11]), 1 = rd (Instr[20:16])
- Immed  out  32  extended/shifted immediate
- RF_A  out  32  RF[rs]
- RF_B  out  32  RF[rt] or RF[rd] per RF_Bsel

Behaviour:
- One clock; reset is synchronous and active-high, using ports Clk and Reset.
- Register file:
  - 32 x 32-bit registers.
  - On Reset at a rising Clk edge, all registers clear to 0. Reset has priority over writes.
  - Write: at rising Clk edge when RF_WrEn=1 and Reset=0, RF[Instr[20:16]] <= (RF_WrData_sel ? MEM_out : ALU_out).
  - Writes to R0 are ignored; R0 always reads 0.
- Reads:
  - Combinational, zero latency: RF_A = RF[Instr[25:21]]; RF_B = RF[RF_Bsel ? Instr[20:16] : Instr[15:11]].
  - Read-during-write to the same register returns the old value until the edge; the new value is visible immediately after the edge.
  - No internal bypass.
- Immed: combinational from opcode = Instr[31:26] and imm16 = Instr[15:0]:
  - lui 111001: {imm16, 16'h0000}
  - andi 110010, ori 110011: zero-extend {16'h0, imm16}
  - b 111111, beq 000000, bne 000001: sign-extend then shift left 2: {{14{imm16[15]}}, imm16, 2'b00}
  - All other opcodes (addi 110000, li 111000, lb 000011, lw 001111, sb 000111, sw 011111, R-type 100000, undefined): sign-extend {{16{imm16[15]}}, imm16}
- Outputs during and after reset:
  - RF_A and RF_B read 0 after a reset edge, since all registers are 0.
  - Immed is purely a function of Instr and is not affected by Reset.
- X/undriven MEM_out is harmless when RF_WrData_sel=0 or RF_WrEn=0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: OP_RTYPE, OP_ADDI, OP_LI, OP_LUI, OP_ANDI, OP_ORI, OP_B, OP_BEQ, OP_BNE, OP_LB, OP_LW, OP_SB, OP_SW
  - field bit-position constants
  - DATA_W
- One sub-module, register_file:
  - ports Clk, Reset, Ard1, Ard2, Awr, Din, WrEn, Dout1, Dout2
  - the decode top instantiates it and adds the write-data mux, read-address mux and immediate extender.

Test Plan:
- Fill and read back: Reset once; Instr = 110000_00100_rd_1000000000000100 with rd = 0..31, RF_WrEn=1, RF_WrData_sel=0, ALU_out = rd (1 for rd=0), one edge each. Then RF_WrEn=0, RF_Bsel=1, Instr = 110000_00100_01001_1000000000000100 -> RF_A = 4, RF_B = 9, Immed = 0xFFFF8004.
- R0 protection: write 1 to rd=0 -> RF_A with rs=0 reads 0.
- RF_Bsel=0 with Instr[15:11] = 00111 -> RF_B = 7.
- Write-data mux: RF_WrData_sel=1, MEM_out=0xDEADBEEF, ALU_out=0x1234, rd=5 -> after the edge RF[5] = 0xDEADBEEF.
- Immediate kinds with imm16 = 0x8004:
  - lui -> 0x80040000
  - ori -> 0x00008004
  - beq -> 0xFFFE0010
  - li -> 0xFFFF8004
- Reset: registers loaded, assert Reset for one edge together with RF_WrEn=1 -> every RF_A/RF_B read is 0 and the concurrent write is dropped. Without RF_WrEn, contents persist across edges.
